// File: rtl/case8_ctrl_pkg.sv
// case8_ctrl_pkg: shared types and constants for the case8 sweep controller and its MISR.
package case8_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
  localparam int VEC_W = 10;
  localparam int RSP_W = 5;
  localparam int CNT_W = 11;
  localparam int SIG_W_DEF = 16;
  localparam logic [VEC_W-1:0] LFSR_TAPS = 10'h240;
  localparam logic [SIG_W_DEF-1:0] MISR_TAPS = 16'hB400;
  localparam logic [CNT_W-1:0] EXH_COUNT = 11'd1024;
  function automatic logic [VEC_W-1:0] lfsr_next(input logic [VEC_W-1:0] v);
    return {v[VEC_W-2:0], ^(v & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/case8_misr.sv
// case8_misr: 16-bit multiple-input signature register folding in one datapath response per enable.
module case8_misr
  import case8_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic [RSP_W-1:0]     din,
  output logic [SIG_W_DEF-1:0] sig
);
  logic [SIG_W_DEF-1:0] sig_q, sig_d;
  always_comb
    sig_d = clr ? '0
          : en  ? ({sig_q[SIG_W_DEF-2:0], ^(sig_q & MISR_TAPS)} ^ {{(SIG_W_DEF-RSP_W){1'b0}}, din})
          : sig_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) sig_q <= '0;
    else     sig_q <= sig_d;
  assign sig = sig_q;
endmodule

// File: rtl/case8_sweep_ctrl.sv
// case8_sweep_ctrl: drives exhaustive or LFSR stimulus into an external datapath and
// compacts its registered responses into a MISR signature compared against a golden value.
module case8_sweep_ctrl
  import case8_ctrl_pkg::*;
#(
  parameter int SIG_W = SIG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             mode,
  input  logic [VEC_W-1:0] seed,
  input  logic [CNT_W-1:0] count,
  input  logic [SIG_W-1:0] golden,
  output logic [VEC_W-1:0] vec_o,
  input  logic [RSP_W-1:0] dut_y,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] sig,
  output logic             pass
);
  state_e           state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [CNT_W-1:0] idx_q, idx_d, count_q, count_d, n;
  logic             mode_q, mode_d;
  logic [SIG_W-1:0] golden_q, golden_d;
  logic             misr_clr, misr_en;
  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    idx_d    = idx_q;
    mode_d   = mode_q;
    count_d  = count_q;
    golden_d = golden_q;
    misr_clr = 1'b0;
    misr_en  = 1'b0;
    n        = mode_q ? count_q : EXH_COUNT;
    if (abort && (state_q == RUN || state_q == DRAIN)) begin
      state_d  = IDLE;
      vec_d    = '0;
      misr_clr = 1'b1;
    end else if (state_q == IDLE && start && !abort) begin
      mode_d   = mode;
      count_d  = count;
      golden_d = golden;
      idx_d    = '0;
      misr_clr = 1'b1;
      state_d  = (mode && count == '0) ? DONE : RUN;
      vec_d    = (!mode || count == '0) ? '0 : (seed == '0) ? 10'd1 : seed;
    end else if (state_q == RUN) begin
      // the first RUN cycle has no response yet; the DRAIN cycle picks up the last one
      misr_en = idx_q != '0;
      idx_d   = idx_q + 1'b1;
      state_d = (idx_q == n - 1'b1) ? DRAIN : RUN;
      vec_d   = (idx_q == n - 1'b1) ? '0 : mode_q ? lfsr_next(vec_q) : vec_q + 1'b1;
    end else if (state_q == DRAIN) begin
      misr_en = 1'b1;
      state_d = DONE;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= IDLE;
      vec_q    <= '0;
      idx_q    <= '0;
      mode_q   <= 1'b0;
      count_q  <= '0;
      golden_q <= '0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      idx_q    <= idx_d;
      mode_q   <= mode_d;
      count_q  <= count_d;
      golden_q <= golden_d;
    end
  case8_misr u_misr (
    .clk (clk),
    .rst (rst),
    .clr (misr_clr),
    .en  (misr_en),
    .din (dut_y),
    .sig (sig)
  );
  assign vec_o = vec_q;
  assign busy  = state_q == RUN || state_q == DRAIN;
  assign done  = state_q == DONE;
  assign pass  = done && sig == golden_q;
endmodule
